// File: rtl/muldiv_hilo_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : muldiv_hilo_unit
// Description : Iterative radix-2 multiply/divide unit with architectural
//               HI/LO registers. It sits beside the execute-stage ALU, and
//               mfhi/mflo read hi_o/lo_o directly. The pipeline stalls while
//               busy_o is high.
//
//   Operations (op_i):
//     0 MULT   1 MULTU   2 DIV   3 DIVU
//     4 MADD   5 MSUB    6 MTHI  7 MTLO
//
//   Ports:
//     clk_i          clock; all state updates on the rising edge
//     rst_i          asynchronous, active-high reset
//     start_i        request strobe; sampled only while idle
//     op_i [2:0]     operation select
//     a_i  [W-1:0]   rs operand (dividend / multiplicand / move source)
//     b_i  [W-1:0]   rt operand (divisor / multiplier)
//     busy_o         high while an iterative op is in flight
//     done_o         one-cycle pulse after HI/LO are written (or after a
//                    rejected divide)
//     div_by_zero_o  one-cycle pulse with done_o for DIV/DIVU with b_i == 0
//     hi_o, lo_o     architectural HI and LO registers
//
//   Parameters:
//     WIDTH          operand width, >= 4 and even
//     CNT_W          iteration counter width (derived; do not override)
//
//   Optional feature macro:
//     MULDIV_EARLY_OUT_EN  when defined, multiplies leave CALC as soon as
//                          the remaining multiplier bits are all zero.
//                          Results are identical; divide latency unchanged.
//
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int DW = 2 * WIDTH;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // The datapath registers are shared between multiply and divide:
  //   multiply: acc = running product magnitude, mcand = multiplicand
  //             (shifted left each step), mplr = multiplier (shifted right)
  //   divide  : acc[WIDTH:0] = partial remainder, mcand[WIDTH-1:0] = divisor,
  //             mplr = dividend shifting out / quotient shifting in
  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     acc_q, acc_d;
  logic [DW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplr_q, mplr_d;
  logic              neg_q, neg_d;    // product / quotient is negative
  logic              rneg_q, rneg_d;  // remainder is negative (dividend sign)
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;

  // --------------------------------------------------------------------------
  // Operand decode at accept
  // --------------------------------------------------------------------------
  logic             w_in_signed;
  logic             w_in_is_div;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  always_comb begin
    w_in_signed = (op_i == OP_MULT) || (op_i == OP_DIV) ||
                  (op_i == OP_MADD) || (op_i == OP_MSUB);
    w_in_is_div = (op_i == OP_DIV) || (op_i == OP_DIVU);
    w_a_neg     = w_in_signed & a_i[WIDTH-1];
    w_b_neg     = w_in_signed & b_i[WIDTH-1];
    // The most-negative value negates to 2^(WIDTH-1), which still fits as
    // an unsigned WIDTH-bit magnitude.
    w_a_mag     = w_a_neg ? -a_i : a_i;
    w_b_mag     = w_b_neg ? -b_i : b_i;
  end

  // --------------------------------------------------------------------------
  // One radix-2 step of each algorithm
  // --------------------------------------------------------------------------
  logic             w_op_is_div;
  logic [DW-1:0]    w_mul_acc;
  logic             w_mul_rest_zero;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH+1:0] w_rem_diff;
  logic             w_q_bit;
  logic [WIDTH:0]   w_rem_next;

  always_comb begin
    w_op_is_div     = (op_q == OP_DIV) || (op_q == OP_DIVU);

    // Shift-add multiply
    w_mul_acc       = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
    // After this step the multiplier is shifted right; if nothing above bit 0
    // remains, every later step would add zero.
    w_mul_rest_zero = (mplr_q[WIDTH-1:1] == '0);

    // Restoring divide: bring in the next dividend bit, trial-subtract the
    // divisor, keep the difference only when it did not borrow.
    w_rem_sh        = {acc_q[WIDTH-1:0], mplr_q[WIDTH-1]};
    w_rem_diff      = {1'b0, w_rem_sh} - {2'b00, mcand_q[WIDTH-1:0]};
    w_q_bit         = ~w_rem_diff[WIDTH+1];
    w_rem_next      = w_q_bit ? w_rem_diff[WIDTH:0] : w_rem_sh;
  end

  // --------------------------------------------------------------------------
  // Sign correction and HI/LO update values used in FIX
  // --------------------------------------------------------------------------
  logic [DW-1:0]    w_prod;
  logic [DW-1:0]    w_hilo;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  always_comb begin
    w_prod = neg_q ? -acc_q : acc_q;
    w_hilo = {hi_q, lo_q};
    // Truncating division: quotient sign is the XOR of operand signs, the
    // remainder follows the dividend. MIN / -1 wraps back to MIN with zero
    // remainder without any special case.
    w_quo  = neg_q  ? -mplr_q : mplr_q;
    w_rem  = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          case (op_i)
            OP_MTHI: begin
              hi_d   = a_i;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = a_i;
              done_d = 1'b1;
            end
            default: begin
              if (w_in_is_div && (b_i == '0)) begin
                // Rejected divide: HI/LO keep their values.
                done_d = 1'b1;
                dbz_d  = 1'b1;
              end else begin
                op_d   = op_i;
                cnt_d  = CNT_INIT;
                acc_d  = '0;
                neg_d  = w_a_neg ^ w_b_neg;
                rneg_d = w_a_neg;
                if (w_in_is_div) begin
                  mcand_d = {{WIDTH{1'b0}}, w_b_mag};
                  mplr_d  = w_a_mag;
                end else begin
                  mcand_d = {{WIDTH{1'b0}}, w_a_mag};
                  mplr_d  = w_b_mag;
                end
                // A zero multiplier has nothing to iterate over.
                if (EARLY_OUT && !w_in_is_div && (w_b_mag == '0)) begin
                  state_d = ST_FIX;
                end else begin
                  state_d = ST_CALC;
                end
              end
            end
          endcase
        end
      end

      ST_CALC: begin
        cnt_d = cnt_q - CNT_ONE;
        if (w_op_is_div) begin
          acc_d  = {{(WIDTH-1){1'b0}}, w_rem_next};
          mplr_d = {mplr_q[WIDTH-2:0], w_q_bit};
        end else begin
          acc_d   = w_mul_acc;
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
        end
        if ((cnt_q == CNT_ONE) ||
            (EARLY_OUT && !w_op_is_div && w_mul_rest_zero)) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        case (op_q)
          OP_MADD:         {hi_d, lo_d} = w_hilo + w_prod;
          OP_MSUB:         {hi_d, lo_d} = w_hilo - w_prod;
          OP_DIV, OP_DIVU: begin
            lo_d = w_quo;
            hi_d = w_rem;
          end
          default:         {hi_d, lo_d} = w_prod;
        endcase
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MULT;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_hilo_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_hilo_unit
// Description : Self-checking bench for muldiv_hilo_unit. A table of directed
//               operations with hand-computed HI/LO results is applied in
//               order (HI/LO carry over between entries), followed by
//               hand-written sequences for busy-time start, mid-op reset and
//               back-to-back accept on a done cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_hilo_unit;

  localparam int W     = 32;
  localparam int LIMIT = 60;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy_o;
  logic         done_o;
  logic         dbz_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int checks   = 0;
  int failures = 0;

  muldiv_hilo_unit #(.WIDTH(W)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .op_i          (op),
    .a_i           (a),
    .b_i           (b),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .div_by_zero_o (dbz_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string name, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%0d] actual=0x%0h required=0x%0h", name, idx, act, exp);
    end
  endtask

  // Expected cycles from the accept edge to the first cycle with done high.
  function automatic int exp_lat(input logic [2:0] o, input logic [W-1:0] bv);
    logic         sgn;
    logic [W-1:0] mag;
    int           msb;
    if (o >= 3'd6) return 1;
    if ((o == 3'd2 || o == 3'd3) && bv == '0) return 1;
    sgn = (o == 3'd0) || (o == 3'd4) || (o == 3'd5);
    mag = (sgn && bv[W-1]) ? -bv : bv;
    msb = -1;
    for (int i = 0; i < W; i++) if (mag[i]) msb = i;
`ifdef MULDIV_EARLY_OUT_EN
    if (o != 3'd2 && o != 3'd3) return (msb < 0) ? 2 : msb + 3;
`endif
    if (msb < -1) return 0;
    return W + 2;
  endfunction

  // Issue one op and wait (bounded) for done. Leaves the bench at the
  // negedge of the done cycle, or after LIMIT cycles with lat = 0.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, output int lat,
                        output int nbusy, output logic dbz);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; op = 3'd0; a = ~av; b = ~bv;  // operands must already be captured
    lat = 0; nbusy = 0; dbz = 1'b0;
    for (int c = 1; c <= LIMIT; c++) begin
      if (busy_o) nbusy++;
      if (done_o) begin
        lat = c;
        dbz = dbz_o;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int   lat, nbusy, el, ndone;
    logic dbz;

    //          op     a              b              hi             lo             dbz
    vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{3'd3, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1};
    vecs[4]  = '{3'd6, 32'h00000000, 32'h12345678, 32'h00000000, 32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{3'd7, 32'h00000010, 32'h12345678, 32'h00000000, 32'h00000010, 1'b0};
    vecs[6]  = '{3'd4, 32'h00000004, 32'hFFFFFFFF, 32'h00000000, 32'h0000000C, 1'b0};
    vecs[7]  = '{3'd5, 32'h00000004, 32'h00000004, 32'hFFFFFFFF, 32'hFFFFFFFC, 1'b0};
    vecs[8]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[9]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[10] = '{3'd3, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999, 1'b0};
    vecs[11] = '{3'd2, 32'hFFFFFFF8, 32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0};
    vecs[12] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[13] = '{3'd0, 32'h00000005, 32'h00000001, 32'h00000000, 32'h00000005, 1'b0};
    vecs[14] = '{3'd1, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
    vecs[15] = '{3'd7, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[16] = '{3'd4, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0};
    vecs[17] = '{3'd5, 32'h00000001, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[18] = '{3'd2, 32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b1};
    vecs[19] = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};

    // Reset
    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 0, 64'(busy_o), 64'd0);
    check("reset_done", 0, 64'(done_o), 64'd0);
    check("reset_dbz",  0, 64'(dbz_o),  64'd0);
    check("reset_hilo", 0, {hi_o, lo_o}, 64'd0);

    // Table-driven operations
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, nbusy, dbz);
      el = exp_lat(vecs[i].op, vecs[i].b);
      check("latency", i, 64'(lat), 64'(el));
      check("busy_cycles", i, 64'(nbusy), (el > 1) ? 64'(el - 1) : 64'd0);
      check("div_by_zero", i, 64'(dbz), 64'(vecs[i].dbz));
      check("hi", i, 64'(hi_o), 64'(vecs[i].hi));
      check("lo", i, 64'(lo_o), 64'(vecs[i].lo));
      @(negedge clk);
      check("done_pulse_end", i, {62'd0, done_o, dbz_o}, 64'd0);
    end

    // Start pulsed during a DIV is ignored: 100 / 7 = 14 rem 2
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    @(negedge clk);                          // cycle 1
    start = 1'b0;
    repeat (4) @(negedge clk);               // cycle 5
    start = 1'b1; op = 3'd3; a = 32'd9; b = 32'd3;
    @(negedge clk);                          // cycle 6
    start = 1'b0;
    lat = 0;
    for (int c = 6; c <= LIMIT; c++) begin
      if (done_o) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    check("busy_start_latency", 0, 64'(lat), 64'(W + 2));
    check("busy_start_hi", 0, 64'(hi_o), 64'd2);
    check("busy_start_lo", 0, 64'(lo_o), 64'd14);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o) ndone++;
    end
    check("busy_start_no_second_done", 0, 64'(ndone), 64'd0);

    // Reset in the middle of a MULT abandons it and clears HI/LO at once
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
    @(negedge clk);                          // cycle 1
    start = 1'b0;
    repeat (9) @(negedge clk);               // cycle 10
    check("pre_reset_busy", 0, 64'(busy_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_busy", 0, 64'(busy_o), 64'd0);
    check("async_reset_hilo", 0, {hi_o, lo_o}, 64'd0);
    check("async_reset_done", 0, 64'(done_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o || busy_o) ndone++;
    end
    check("reset_abandons_op", 0, 64'(ndone), 64'd0);
    check("reset_hilo_stays", 0, {hi_o, lo_o}, 64'd0);

    // A start on a done cycle is accepted
    @(negedge clk);
    start = 1'b1; op = 3'd6; a = 32'h000000AA; b = '0;
    @(negedge clk);                          // done for MTHI
    check("b2b_first_done", 0, 64'(done_o), 64'd1);
    start = 1'b1; op = 3'd7; a = 32'h00000055;
    @(negedge clk);
    start = 1'b0;
    check("b2b_second_done", 0, 64'(done_o), 64'd1);
    check("b2b_hilo", 0, {hi_o, lo_o}, {32'h000000AA, 32'h00000055});
    @(negedge clk);
    check("b2b_done_end", 0, 64'(done_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
